timer_dev: RTL

- Memory-mapped countdown timer that sits on the device side of the CPU bridge bus.
- It is the responder to the processor's pr_addr / pr_data_out / pr_data_in accesses.
- It raises an interrupt line that the bridge routes onto one hw_int bit of CP0.
- Register window is 3 words, word-addressed by addr[3:2]: CTRL, PRESET, COUNT.

---
 rtl/timer_dev.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped countdown timer on the device side of the CPU bridge bus.
//
// Register window (word-addressed by bus address bits [3:2]):
//   0 CTRL   [0] EN, [2:1] MODE (01 auto-reload, anything else one-shot),
//            [3] IM (1 = interrupt allowed), [31:4] read as zero
//   1 PRESET reload value copied into COUNT on every LOAD
//   2 COUNT  current down-counter value (read-only)
//   3 unmapped, reads zero, writes ignored
//
// Ports:
//   clk   system clock, rising edge
//   rst   synchronous active-high reset
//   addr  word select
//   we    write strobe, sampled at rising clk
//   din   write data from the CPU
//   dout  read data to the CPU, combinational from addr, no read side effects
//   irq   interrupt request (irq_pending & IM) routed to a CP0 hw_int bit
//
// Build option: define TIMER_PRESCALE_EN to divide the CNT step rate by PRESCALE.
// Without it every CNT cycle is a counting step and no prescale counter exists.

module timer_dev #(
  parameter int unsigned PRESCALE = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] AddrCtrl   = 2'd0;
  localparam logic [1:0] AddrPreset = 2'd1;
  localparam logic [1:0] AddrCount  = 2'd2;

  localparam logic [1:0] ModeAuto = 2'b01;

  if (PRESCALE < 1 || PRESCALE > 65535) begin : g_bad_prescale
    $error("timer_dev: PRESCALE must be within 1..65535");
  end

  typedef enum logic [1:0] {
    StIdle,
    StLoad,
    StCnt,
    StInt
  } state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_pending_q, irq_pending_d;

  logic ctrl_en;
  logic ctrl_auto;
  logic ctrl_im;
  logic ctrl_wr;
  logic preset_wr;
  logic tick;
  logic int_enter;

  assign ctrl_en   = ctrl_q[0];
  assign ctrl_auto = (ctrl_q[2:1] == ModeAuto);
  assign ctrl_im   = ctrl_q[3];
  assign ctrl_wr   = we && (addr == AddrCtrl);
  assign preset_wr = we && (addr == AddrPreset);

`ifdef TIMER_PRESCALE_EN
  // Prescale counter only advances while counting; it sits at zero in every
  // other state so each CNT phase starts with a full PRESCALE-cycle step.
  logic [15:0] pre_q, pre_d;
  logic        pre_wrap;

  assign pre_wrap = (pre_q == 16'(PRESCALE - 1));
  assign tick     = pre_wrap;

  always_comb begin
    pre_d = '0;
    if (state_q == StCnt && ctrl_en) begin
      pre_d = pre_wrap ? '0 : pre_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q <= '0;
    end else begin
      pre_q <= pre_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // FSM and register next-state.
  always_comb begin
    state_d       = state_q;
    ctrl_d        = ctrl_q;
    preset_d      = preset_q;
    count_d       = count_q;
    irq_pending_d = irq_pending_q;
    int_enter     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_en) begin
          state_d = StLoad;
        end
      end
      StLoad: begin
        count_d = preset_q;
        state_d = StCnt;
      end
      StCnt: begin
        if (!ctrl_en) begin
          state_d = StIdle;
        end else if (tick) begin
          // PRESET of 0 and 1 both expire on the first step; COUNT never wraps.
          if (count_q <= 32'd1) begin
            count_d   = '0;
            state_d   = StInt;
            int_enter = 1'b1;
          end else begin
            count_d = count_q - 32'd1;
          end
        end
      end
      StInt: begin
        if (ctrl_auto) begin
          irq_pending_d = 1'b0;
          state_d       = StLoad;
        end else begin
          ctrl_d[0] = 1'b0;
          state_d   = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // A CPU write to CTRL overrides the FSM's own EN clear and acknowledges
    // any held interrupt, except one being raised on this very edge.
    if (ctrl_wr) begin
      ctrl_d = din[3:0];
      if (!int_enter) begin
        irq_pending_d = 1'b0;
      end
    end

    if (int_enter) begin
      irq_pending_d = 1'b1;
    end

    // PRESET only lands in COUNT at the next LOAD.
    if (preset_wr) begin
      preset_d = din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      ctrl_q        <= '0;
      preset_q      <= '0;
      count_q       <= '0;
      irq_pending_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      ctrl_q        <= ctrl_d;
      preset_q      <= preset_d;
      count_q       <= count_d;
      irq_pending_q <= irq_pending_d;
    end
  end

  // Read mux.
  always_comb begin
    dout = '0;
    case (addr)
      AddrCtrl:   dout = {28'd0, ctrl_q};
      AddrPreset: dout = preset_q;
      AddrCount:  dout = count_q;
      default:    dout = '0;
    endcase
  end

  assign irq = irq_pending_q & ctrl_im;

endmodule
